lfsr_galois_param: RTL and testbench

LFSR_GALOIS_PARAM -- requirements
Module: lfsr_galois_param

---
 rtl/lfsr_galois_param_pkg.sv | 53 +++++
 rtl/lfsr_step.sv | 23 ++
 rtl/lfsr_galois_param.sv | 117 +++++++++++
 tb/tb_lfsr_galois_param.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/lfsr_galois_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_galois_param_pkg
// Brief    : Default primitive feedback taps per width (3..32) and seed constant.
// Revision : 1.0
// ============================================================================
package lfsr_galois_param_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    localparam logic [MAX_WIDTH-1:0] SEED_ONES = '1;

    // Bit i set = coefficient of x^i in a primitive polynomial of degree w.
    function automatic logic [MAX_WIDTH-1:0] default_taps(input int unsigned w);
        logic [MAX_WIDTH-1:0] t;
        case (w)
            3:       t = 32'h0000_0002;
            4:       t = 32'h0000_0002;
            5:       t = 32'h0000_0004;
            6:       t = 32'h0000_0002;
            7:       t = 32'h0000_0002;
            8:       t = 32'h0000_0070;
            9:       t = 32'h0000_0010;
            10:      t = 32'h0000_0008;
            11:      t = 32'h0000_0004;
            12:      t = 32'h0000_0052;
            13:      t = 32'h0000_001A;
            14:      t = 32'h0000_0442;
            15:      t = 32'h0000_0002;
            16:      t = 32'h0000_100A;
            17:      t = 32'h0000_0008;
            18:      t = 32'h0000_0080;
            19:      t = 32'h0000_0026;
            20:      t = 32'h0000_0008;
            21:      t = 32'h0000_0004;
            22:      t = 32'h0000_0002;
            23:      t = 32'h0000_0020;
            24:      t = 32'h0000_0086;
            25:      t = 32'h0000_0008;
            26:      t = 32'h0000_0046;
            27:      t = 32'h0000_0026;
            28:      t = 32'h0000_0008;
            29:      t = 32'h0000_0004;
            30:      t = 32'h0000_0052;
            31:      t = 32'h0000_0008;
            32:      t = 32'h0040_0006;
            default: t = 32'h0000_0002;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_step
// Brief    : Combinational Galois shift-left next-state function.
// Revision : 1.0
// ============================================================================
module lfsr_step #(
    parameter int unsigned      WIDTH = 6,
    parameter logic [WIDTH-1:0] TAPS  = 6'b000010
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o[0] = state_i[WIDTH-1];
        for (int i = 1; i < int'(WIDTH); i++) begin
            next_o[i] = state_i[i-1] ^ (state_i[WIDTH-1] & TAPS[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_galois_param.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_galois_param
// Brief    : Handshaked Galois LFSR with zero-state recovery and period measure.
// Revision : 1.0
// ============================================================================
module lfsr_galois_param
    import lfsr_galois_param_pkg::*;
#(
    parameter int unsigned      WIDTH        = 6,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(SEED_ONES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] q_o,
    output logic             out_valid_o,
    output logic             lockup_o,
    output logic             period_done_o,
    output logic [WIDTH-1:0] period_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             armed_q;
    logic             lockup_q, lockup_d;
    logic             pdone_q, pdone_d;

    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_xfer;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state_i (state_q),
        .next_o  (w_step)
    );

    assign w_xfer    = en_i & valid_q & out_ready_i;
    assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

    // Priority: load, then zero-state recovery, then a handshake transfer.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        lockup_d = 1'b0;
        pdone_d  = 1'b0;
        valid_d  = armed_q;
        if (load_i) begin
            valid_d = 1'b0;
            if (seed_i == '0) begin
                state_d  = SEED_DEFAULT;
                lockup_d = 1'b1;
            end else begin
                state_d = seed_i;
            end
            start_d = state_d;
            cnt_d   = '0;
        end else if (state_q == '0) begin
            state_d  = SEED_DEFAULT;
            start_d  = SEED_DEFAULT;
            cnt_d    = '0;
            lockup_d = 1'b1;
        end else if (w_xfer) begin
            state_d = w_step;
            if (w_step == start_q) begin
                period_d = w_cnt_inc;
                pdone_d  = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = w_cnt_inc;
            end
        end
    end

    // armed_q delays out_valid by one extra edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEED_DEFAULT;
            start_q  <= SEED_DEFAULT;
            cnt_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            armed_q  <= 1'b0;
            lockup_q <= 1'b0;
            pdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            armed_q  <= 1'b1;
            lockup_q <= lockup_d;
            pdone_q  <= pdone_d;
        end
    end

    assign q_o           = state_q;
    assign out_valid_o   = valid_q;
    assign lockup_o      = lockup_q;
    assign period_done_o = pdone_q;
    assign period_o      = period_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_galois_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_galois_param
// Brief    : Directed self-checking bench for lfsr_galois_param (defaults).
// Revision : 1.0
// ============================================================================
module tb_lfsr_galois_param;

    localparam int W = 6;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         en    = 1'b0;
    logic         load  = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] seed  = '0;
    logic [W-1:0] q;
    logic         valid;
    logic         lockup;
    logic         pdone;
    logic [W-1:0] period;

    int n_vec = 0;
    int n_err = 0;

    lfsr_galois_param dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en),
        .load_i        (load),
        .seed_i        (seed),
        .out_ready_i   (ready),
        .q_o           (q),
        .out_valid_o   (valid),
        .lockup_o      (lockup),
        .period_done_o (pdone),
        .period_o      (period)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] walk [6];
        int pulses;
        int pulse_at;

        walk[0] = 6'b000010; walk[1] = 6'b000100; walk[2] = 6'b001000;
        walk[3] = 6'b010000; walk[4] = 6'b100000; walk[5] = 6'b000011;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_q",      q,      32'h3F);
        check("rst_valid",  valid,  32'h0);
        check("rst_lockup", lockup, 32'h0);
        check("rst_pdone",  pdone,  32'h0);
        check("rst_period", period, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rel_valid_e1", valid, 32'h0);
        tick();
        check("rel_valid_e2", valid, 32'h1);

        // Walk from seed 1
        load = 1'b1; seed = 6'b000001; en = 1'b1; ready = 1'b1;
        tick();
        check("load1_q",      q,      32'h01);
        check("load1_valid",  valid,  32'h0);
        check("load1_lockup", lockup, 32'h0);
        load = 1'b0;
        tick();
        check("load1_hold_q", q,     32'h01);
        check("load1_valid2", valid, 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("walk_%0d", i), q, 32'(walk[i]));
        end
        check("walk_cnt", dut.cnt_q, 32'd6);

        // Zero seed substitution
        load = 1'b1; seed = '0;
        tick();
        check("zseed_q",      q,      32'h3F);
        check("zseed_lockup", lockup, 32'h1);
        check("zseed_valid",  valid,  32'h0);
        load = 1'b0;
        tick();
        check("zseed_lockup_end", lockup,    32'h0);
        check("zseed_q_hold",     q,         32'h3F);
        check("zseed_cnt",        dut.cnt_q, 32'd0);

        // Ready toggling
        ready = 1'b1; tick(); check("rdy1_q", q, 32'h3D);
        ready = 1'b0; tick(); check("rdy0_q", q, 32'h3D);
        ready = 1'b1; tick(); check("rdy2_q", q, 32'h39);
        ready = 1'b0; tick(); check("rdy3_q", q, 32'h39);
        check("rdy_cnt", dut.cnt_q, 32'd2);

        // Backdoor zero state recovery
        ready = 1'b1; tick();
        check("pre_zero_q", q, 32'h31);
        force dut.state_q = '0;
        #1 release dut.state_q;
        check("forced_zero_q", q, 32'h0);
        tick();
        check("zrec_q",      q,         32'h3F);
        check("zrec_lockup", lockup,    32'h1);
        check("zrec_cnt",    dut.cnt_q, 32'd0);
        tick();
        check("zrec_lockup_end", lockup,    32'h0);
        check("zrec_step_q",     q,         32'h3D);
        check("zrec_step_cnt",   dut.cnt_q, 32'd1);

        // Load beats zero-state recovery
        force dut.state_q = '0;
        #1 release dut.state_q;
        load = 1'b1; seed = 6'd5;
        tick();
        check("ldzero_q",      q,      32'h05);
        check("ldzero_lockup", lockup, 32'h0);
        load = 1'b0;

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_q",     q,         32'h3F);
        check("arst_valid", valid,     32'h0);
        check("arst_cnt",   dut.cnt_q, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_valid_e1", valid, 32'h0);
        tick();
        check("arst_valid_e2", valid, 32'h1);

        // Full period from reset defaults, twice
        pulses = 0; pulse_at = 0;
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (pdone === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        check("per1_pulses", 32'(pulses),   32'd1);
        check("per1_at",     32'(pulse_at), 32'd63);
        check("per1_period", period,        32'd63);
        check("per1_q",      q,             32'h3F);
        tick();
        check("per_pdone_drop",  pdone,  32'h0);
        check("per_period_held", period, 32'd63);
        pulses = 0; pulse_at = 0;
        for (int k = 2; k <= 63; k++) begin
            tick();
            if (pdone === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        check("per2_pulses", 32'(pulses),   32'd1);
        check("per2_at",     32'(pulse_at), 32'd63);
        check("per2_period", period,        32'd63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
